// File: rtl/pwm_pkg.sv
// Shared types and reset defaults for the PWM parameter loader.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } loaderState_t;

  localparam int PKG_BIT_WIDTH     = 16;
  localparam int PKG_DEF_MAX_COUNT = 1000;
  localparam int PKG_DEF_COMPARE   = 500;
  localparam int PKG_DEF_STEP      = 1;
  localparam int PKG_DEF_DEAD      = 10;

endpackage

// File: rtl/pwm_param_sanitize.sv
// Combinational clamp of a requested parameter set into a self-consistent one.
// Each rule builds on the already-corrected MaxCount, so the order matters.
module pwm_param_sanitize #(
  parameter int BIT_WIDTH = pwm_pkg::PKG_BIT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] rawCompare,
  input  logic [BIT_WIDTH-1:0] rawMaxCount,
  input  logic [BIT_WIDTH-1:0] rawStepSize,
  input  logic [BIT_WIDTH-1:0] rawDeadTime,
  output logic [BIT_WIDTH-1:0] sanCompare,
  output logic [BIT_WIDTH-1:0] sanMaxCount,
  output logic [BIT_WIDTH-1:0] sanStepSize,
  output logic [BIT_WIDTH-1:0] sanDeadTime,
  output logic                 clamped
);

  logic [BIT_WIDTH-1:0] maxFixed;
  logic [BIT_WIDTH-1:0] stepFloor;
  logic [BIT_WIDTH-1:0] halfMax;
  logic                 maxHit;
  logic                 stepZeroHit;
  logic                 stepHit;
  logic                 cmpHit;
  logic                 deadHit;

  always_comb begin
    maxHit      = (rawMaxCount == '0);
    maxFixed    = maxHit ? BIT_WIDTH'(1) : rawMaxCount;

    stepZeroHit = (rawStepSize == '0);
    stepFloor   = stepZeroHit ? BIT_WIDTH'(1) : rawStepSize;
    stepHit     = (stepFloor > maxFixed);
    sanStepSize = stepHit ? maxFixed : stepFloor;

    cmpHit      = (rawCompare > maxFixed);
    sanCompare  = cmpHit ? maxFixed : rawCompare;

    // Dead time may not exceed half the period on either edge of the carrier.
    halfMax     = maxFixed >> 1;
    deadHit     = (rawDeadTime > halfMax);
    sanDeadTime = deadHit ? halfMax : rawDeadTime;

    sanMaxCount = maxFixed;
    clamped     = maxHit | stepZeroHit | stepHit | cmpHit | deadHit;
  end

endmodule

// File: rtl/pwm_param_loader.sv
// Double-buffered parameter loader: host writes land in a shadow set and are
// promoted atomically to the active PWM outputs on the next carrier period start.
module pwm_param_loader
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH     = PKG_BIT_WIDTH,
  parameter int DEF_MAX_COUNT = PKG_DEF_MAX_COUNT,
  parameter int DEF_COMPARE   = PKG_DEF_COMPARE,
  parameter int DEF_STEP      = PKG_DEF_STEP,
  parameter int DEF_DEAD      = PKG_DEF_DEAD
) (
  input  logic                 MClk,
  input  logic                 Rst,
  input  logic                 WrValid,
  output logic                 WrReady,
  input  logic [BIT_WIDTH-1:0] WrCompare,
  input  logic [BIT_WIDTH-1:0] WrMaxCount,
  input  logic [BIT_WIDTH-1:0] WrStepSize,
  input  logic [BIT_WIDTH-1:0] WrDeadTime,
  input  logic                 PeriodSync,
  input  logic                 ClearFlags,
  output logic [BIT_WIDTH-1:0] Compare,
  output logic [BIT_WIDTH-1:0] PWMMaxCount,
  output logic [BIT_WIDTH-1:0] TriangleStepSize,
  output logic [BIT_WIDTH-1:0] DeadTimeCount,
  output logic                 Committed,
  output logic                 Pending,
  output logic                 ClampFlag,
  output logic                 OverwriteFlag
);

  typedef struct packed {
    logic [BIT_WIDTH-1:0] compare;
    logic [BIT_WIDTH-1:0] maxCount;
    logic [BIT_WIDTH-1:0] stepSize;
    logic [BIT_WIDTH-1:0] deadTime;
  } paramSet_t;

  localparam paramSet_t DEF_SET = '{
    compare:  BIT_WIDTH'(DEF_COMPARE),
    maxCount: BIT_WIDTH'(DEF_MAX_COUNT),
    stepSize: BIT_WIDTH'(DEF_STEP),
    deadTime: BIT_WIDTH'(DEF_DEAD)
  };

  loaderState_t state;
  loaderState_t stateNext;

  paramSet_t sanSet;
  paramSet_t shadowSet;
  paramSet_t stage2Set;
  paramSet_t activeSet;
  logic      stage2Valid;
  logic      sanClamped;

  logic loadShadow;
  logic loadStage2;
  logic promoteStage2;
  logic commitNow;
  logic overwriteEv;
  logic clampEv;

  pwm_param_sanitize #(
    .BIT_WIDTH (BIT_WIDTH)
  ) uSanitize (
    .rawCompare  (WrCompare),
    .rawMaxCount (WrMaxCount),
    .rawStepSize (WrStepSize),
    .rawDeadTime (WrDeadTime),
    .sanCompare  (sanSet.compare),
    .sanMaxCount (sanSet.maxCount),
    .sanStepSize (sanSet.stepSize),
    .sanDeadTime (sanSet.deadTime),
    .clamped     (sanClamped)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge MClk) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    stateNext     = state;
    WrReady       = 1'b1;
    Committed     = 1'b0;
    loadShadow    = 1'b0;
    loadStage2    = 1'b0;
    promoteStage2 = 1'b0;
    commitNow     = 1'b0;
    overwriteEv   = 1'b0;
    // WrReady depends only on state, so WrValid alone qualifies a transfer here.
    case (state)
      IDLE: begin
        if (WrValid) begin
          loadShadow = 1'b1;
          stateNext  = PENDING;
        end
      end
      PENDING: begin
        if (PeriodSync) begin
          commitNow  = 1'b1;
          loadStage2 = WrValid;
          stateNext  = COMMIT;
        end else if (WrValid) begin
          loadShadow  = 1'b1;
          overwriteEv = 1'b1;
        end
      end
      COMMIT: begin
        WrReady   = 1'b0;
        Committed = 1'b1;
        if (stage2Valid) begin
          promoteStage2 = 1'b1;
          stateNext     = PENDING;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign clampEv = (loadShadow | loadStage2) & sanClamped;
  assign Pending = (state == PENDING) | stage2Valid;

  // NOTE: the shadow registers are reset as well, so a reset mid-transaction
  // can never leak a stale set into a later commit.
  always_ff @(posedge MClk) begin
    if (Rst) begin
      shadowSet   <= '0;
      stage2Set   <= '0;
      stage2Valid <= 1'b0;
      activeSet   <= DEF_SET;
    end else begin
      if (loadShadow)         shadowSet <= sanSet;
      else if (promoteStage2) shadowSet <= stage2Set;

      if (loadStage2) begin
        stage2Set   <= sanSet;
        stage2Valid <= 1'b1;
      end else if (promoteStage2) begin
        stage2Valid <= 1'b0;
      end

      if (commitNow) activeSet <= shadowSet;
    end
  end

  // A set event in the same cycle as ClearFlags keeps the flag raised.
  always_ff @(posedge MClk) begin
    if (Rst) begin
      ClampFlag     <= 1'b0;
      OverwriteFlag <= 1'b0;
    end else begin
      if (clampEv)         ClampFlag <= 1'b1;
      else if (ClearFlags) ClampFlag <= 1'b0;

      if (overwriteEv)     OverwriteFlag <= 1'b1;
      else if (ClearFlags) OverwriteFlag <= 1'b0;
    end
  end

  assign Compare          = activeSet.compare;
  assign PWMMaxCount      = activeSet.maxCount;
  assign TriangleStepSize = activeSet.stepSize;
  assign DeadTimeCount    = activeSet.deadTime;

endmodule

// File: tb/tb_pwm_param_loader.sv
// Scoreboard bench for pwm_param_loader: a queue-based reference model predicts
// status every cycle and the exact set delivered by every commit.
module tb_pwm_param_loader;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] cmp;
    logic [W-1:0] max;
    logic [W-1:0] step;
    logic [W-1:0] dead;
  } pset_t;

  typedef logic [5+4*W-1:0] status_t;

  localparam pset_t DEF_SET = '{cmp: 16'd500, max: 16'd1000, step: 16'd1, dead: 16'd10};

  logic         MClk;
  logic         Rst;
  logic         WrValid;
  logic         WrReady;
  logic [W-1:0] WrCompare;
  logic [W-1:0] WrMaxCount;
  logic [W-1:0] WrStepSize;
  logic [W-1:0] WrDeadTime;
  logic         PeriodSync;
  logic         ClearFlags;
  logic [W-1:0] Compare;
  logic [W-1:0] PWMMaxCount;
  logic [W-1:0] TriangleStepSize;
  logic [W-1:0] DeadTimeCount;
  logic         Committed;
  logic         Pending;
  logic         ClampFlag;
  logic         OverwriteFlag;

  pwm_param_loader dut (
    .MClk             (MClk),
    .Rst              (Rst),
    .WrValid          (WrValid),
    .WrReady          (WrReady),
    .WrCompare        (WrCompare),
    .WrMaxCount       (WrMaxCount),
    .WrStepSize       (WrStepSize),
    .WrDeadTime       (WrDeadTime),
    .PeriodSync       (PeriodSync),
    .ClearFlags       (ClearFlags),
    .Compare          (Compare),
    .PWMMaxCount      (PWMMaxCount),
    .TriangleStepSize (TriangleStepSize),
    .DeadTimeCount    (DeadTimeCount),
    .Committed        (Committed),
    .Pending          (Pending),
    .ClampFlag        (ClampFlag),
    .OverwriteFlag    (OverwriteFlag)
  );

  initial begin
    MClk = 1'b0;
    forever #5 MClk = ~MClk;
  end

  int passCount = 0;
  int checkCount = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: sets waiting for a period start, in commit order.
  pset_t   held[$];
  pset_t   commitQ[$];
  status_t statusQ[$];
  pset_t   mActive = DEF_SET;
  bit      mBusy = 1'b0;
  bit      mComm = 1'b0;
  bit      mClamp = 1'b0;
  bit      mOv = 1'b0;

  function automatic logic [W-1:0] umin(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic pset_t sanitizeModel(input pset_t raw);
    pset_t o;
    o.max  = (raw.max == 0) ? 16'd1 : raw.max;
    o.step = umin((raw.step == 0) ? 16'd1 : raw.step, o.max);
    o.cmp  = umin(raw.cmp, o.max);
    o.dead = umin(raw.dead, o.max / 2);
    return o;
  endfunction

  task automatic modelStep(input bit v, input bit s, input bit c, input bit r, input pset_t d);
    pset_t san;
    bit    clampEv;
    bit    ovEv;
    san     = sanitizeModel(d);
    clampEv = 1'b0;
    ovEv    = 1'b0;
    if (r) begin
      held.delete();
      mBusy   = 1'b0;
      mComm   = 1'b0;
      mActive = DEF_SET;
      mClamp  = 1'b0;
      mOv     = 1'b0;
    end else begin
      mComm = 1'b0;
      if (mBusy) begin
        mBusy = 1'b0;
      end else begin
        if (v) clampEv = (san != d);
        if (s && held.size() > 0) begin
          mActive = held.pop_front();
          commitQ.push_back(mActive);
          mComm = 1'b1;
          mBusy = 1'b1;
          if (v) held.push_back(san);
        end else if (v) begin
          if (held.size() > 0) begin
            held[0] = san;
            ovEv = 1'b1;
          end else begin
            held.push_back(san);
          end
        end
      end
      mClamp = clampEv ? 1'b1 : (c ? 1'b0 : mClamp);
      mOv    = ovEv    ? 1'b1 : (c ? 1'b0 : mOv);
    end
    statusQ.push_back({!mBusy, mComm, held.size() > 0, mClamp, mOv, mActive});
  endtask

  // Monitor: status every cycle, and the committed set whenever Committed pulses.
  initial begin
    status_t expS;
    pset_t   expC;
    forever begin
      @(posedge MClk);
      #1;
      if (statusQ.size() > 0) begin
        expS = statusQ.pop_front();
        check("status", {WrReady, Committed, Pending, ClampFlag, OverwriteFlag,
                         Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount}, expS);
      end
      if (Committed === 1'b1) begin
        if (commitQ.size() == 0) begin
          check("unexpected_commit", Committed, 1'b0);
        end else begin
          expC = commitQ.pop_front();
          check("commit_set", {Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount}, expC);
        end
      end
    end
  end

  function automatic pset_t mk(input int c, input int m, input int s, input int d);
    return '{cmp: W'(c), max: W'(m), step: W'(s), dead: W'(d)};
  endfunction

  task automatic cyc(input bit v, input bit s, input bit c, input bit r, input pset_t d);
    @(negedge MClk);
    WrValid    = v;
    PeriodSync = s;
    ClearFlags = c;
    Rst        = r;
    {WrCompare, WrMaxCount, WrStepSize, WrDeadTime} = d;
    modelStep(v, s, c, r, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic peek();
    @(posedge MClk);
    #2;
  endtask

  function automatic logic [W-1:0] rndVal(input int hi);
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return W'($urandom_range(1, 4));
      default: return W'($urandom_range(0, hi));
    endcase
  endfunction

  initial begin
    Rst = 1'b1;
    WrValid = 1'b0;
    PeriodSync = 1'b0;
    ClearFlags = 1'b0;
    {WrCompare, WrMaxCount, WrStepSize, WrDeadTime} = '0;

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(1);
    peek();
    check("rst_outputs", {Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount},
          {16'd500, 16'd1000, 16'd1, 16'd10});
    check("rst_ready", WrReady, 1'b1);
    check("rst_flags", {Committed, Pending, ClampFlag, OverwriteFlag}, 4'b0000);

    // Basic write, period start five cycles later.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(300, 800, 2, 20));
    idle(4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    peek();
    check("basic_commit", {Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount, Committed},
          {16'd300, 16'd800, 16'd2, 16'd20, 1'b1});
    idle(1);
    peek();
    check("basic_after", {Committed, Pending, WrReady}, 3'b001);

    // Clamped write, then flag clear.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(900, 800, 0, 500));
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    peek();
    check("clamp_commit", {Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount, ClampFlag},
          {16'd800, 16'd800, 16'd1, 16'd400, 1'b1});
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    peek();
    check("clamp_cleared", ClampFlag, 1'b0);

    // Two writes before the period start: last write wins.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(100, 400, 3, 50));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(200, 600, 4, 60));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    peek();
    check("overwrite_commit", {Compare, PWMMaxCount, OverwriteFlag}, {16'd200, 16'd600, 1'b1});
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Write coincident with period start while a set is pending.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(111, 500, 5, 30));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, mk(222, 700, 6, 40));
    peek();
    check("dual_first", {Compare, Pending, OverwriteFlag, WrReady}, {16'd111, 1'b1, 1'b0, 1'b0});
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    peek();
    check("dual_second", {Compare, PWMMaxCount, Committed}, {16'd222, 16'd700, 1'b1});

    // Write with period start while idle: the sync is ignored.
    idle(1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, mk(50, 300, 1, 5));
    peek();
    check("idle_sync_ignored", {Compare, Committed, Pending}, {16'd222, 1'b0, 1'b1});
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    peek();
    check("idle_sync_later", {Compare, PWMMaxCount}, {16'd50, 16'd300});

    // Clamp event and clear in the same cycle: set wins.
    idle(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, mk(10, 0, 0, 0));
    peek();
    check("clamp_set_wins", ClampFlag, 1'b1);

    // Reset while pending discards the shadow.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(333, 900, 7, 70));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    peek();
    check("rst_discard", {Compare, PWMMaxCount, Committed, Pending}, {16'd500, 16'd1000, 1'b0, 1'b0});

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      pset_t d;
      d.cmp  = rndVal(1500);
      d.max  = rndVal(1200);
      d.step = rndVal(1500);
      d.dead = rndVal(900);
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
          $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, d);
    end
    idle(2);
    @(posedge MClk);
    #3;
    check("status_drained", statusQ.size(), 0);
    check("commit_drained", commitQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pwm_param_loader.md
PWM_PARAM_LOADER -- requirements
Module: pwm_param_loader

Interface
REQ-001 Parameter BIT_WIDTH, default 16, width of every count/compare field.
REQ-002 Parameter DEF_MAX_COUNT, default 1000, PWMMaxCount after reset.
REQ-003 Parameter DEF_COMPARE, default 500, Compare after reset.
REQ-004 Parameter DEF_STEP, default 1, TriangleStepSize after reset.
REQ-005 Parameter DEF_DEAD, default 10, DeadTimeCount after reset.
REQ-006 One clock; reset is synchronous and active-high: MClk in 1 (all state on rising edge); Rst in 1 (sync, active-high).
REQ-007 WrValid  in  1  host offers a new parameter set.
REQ-008 WrReady  out  1  loader can accept a set this cycle.
REQ-009 WrCompare, WrMaxCount, WrStepSize, WrDeadTime  in  BIT_WIDTH each  requested values.
REQ-010 PeriodSync  in  1  one-cycle pulse at carrier period start.
REQ-011 ClearFlags  in  1  clears sticky flags.
REQ-012 Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount  out  BIT_WIDTH each  active values driving the PWM generator.
REQ-013 Committed  out  1  one-cycle pulse, active set just updated.
REQ-014 Pending  out  1  shadow set awaiting commit.
REQ-015 ClampFlag  out  1  sticky, a written field was sanitised.
REQ-016 OverwriteFlag  out  1  sticky, an uncommitted shadow set was replaced.

Function
REQ-017 Handshake: transfer occurs when WrValid && WrReady; WrValid may be held, no combinational path from WrValid to WrReady.
REQ-018 States IDLE, PENDING, COMMIT; WrReady = 1 in IDLE and PENDING, 0 in COMMIT.
REQ-019 IDLE: transfer -> shadow written next edge, go PENDING; PeriodSync in same cycle ignored (commit waits for next PeriodSync).
REQ-020 PENDING: PeriodSync -> go COMMIT; transfer without PeriodSync -> shadow replaced (last write wins), OverwriteFlag set.
REQ-021 PENDING with transfer and PeriodSync in same cycle: existing shadow is committed, new set captured into second-stage shadow, next state COMMIT then PENDING; OverwriteFlag not set.
REQ-022 COMMIT: active outputs take shadow values at this edge, Committed = 1 for exactly this cycle, next state PENDING if a set was captured per REQ-021 else IDLE.
REQ-023 Latency: active outputs change exactly 1 cycle after the accepting PeriodSync cycle; all four outputs change on the same edge, never partially.
REQ-024 Sanitise at capture, in order: MaxCount 0 -> 1; StepSize 0 -> 1; StepSize > MaxCount -> MaxCount; Compare > MaxCount -> MaxCount; DeadTime > MaxCount>>1 -> MaxCount>>1; any substitution sets ClampFlag.
REQ-025 All comparisons unsigned BIT_WIDTH; no arithmetic widening on outputs.
REQ-026 ClampFlag/OverwriteFlag clear on ClearFlags; a set event in the same cycle as ClearFlags wins (flag remains 1).
REQ-027 Pending = 1 in PENDING and whenever second-stage shadow holds a set.
REQ-028 PeriodSync with no pending set: no output change, no Committed pulse.

Reset
REQ-029 Rst: state IDLE, outputs = DEF_* values, shadows cleared, WrReady 1 on first cycle after release, Committed/Pending/flags 0.
REQ-030 Rst mid-operation (PENDING or COMMIT) discards shadow sets; no commit occurs.

Structure
REQ-031 Shared package pwm_pkg holds state enum, BIT_WIDTH default and DEF_* constants.
REQ-032 One combinational sub-module pwm_param_sanitize implements REQ-024 and returns clamp indication.

Verification
REQ-033 Reset release -> outputs 500/1000/1/10, WrReady 1, flags 0.
REQ-034 Write (300,800,2,20), PeriodSync 5 cycles later -> outputs change 1 cycle after sync, Committed pulse one cycle, Pending 0.
REQ-035 Write Compare=900, MaxCount=800, Step=0, Dead=500 -> commit 800/800/1/400, ClampFlag 1; ClearFlags -> 0.
REQ-036 Two writes before sync -> second set committed, OverwriteFlag 1.
REQ-037 Write coincident with PeriodSync while PENDING -> first set committed, second committed at next PeriodSync.
REQ-038 Rst asserted in PENDING, then PeriodSync -> outputs stay at defaults, no Committed.
